if_fetch_ctrl: RTL
==================

Name: if_fetch_ctrl

Overview:
Sequences the IF0 fetch stage of the LoongArch-32 pipeline.
- Owns the fetch PC and issues one ICache request at a time over the req/addr_ok/data_ok handshake.
- Applies load-use stalls and branch/exception redirects.
- Discards stale responses after a redirect.
- Drives the PC/valid pair into the IF0→IF1 pipeline register.

Parameters:
- PC_RST, 32'h1c000000, fetch PC after reset (shared constant).
- WORD, 32, address/data width.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset; synchronous, active-high.
- stall_in, in, 1, load-use stall; IF0→IF1 register holds this cycle.
- redirect_valid, in, 1, branch/exception redirect request.
- redirect_pc, in, WORD, redirect target.
- icache_req, out, 1, fetch request.
- icache_addr, out, WORD, fetch address (= pc_r).
- icache_addr_ok, in, 1, request accepted.
- icache_data_ok, in, 1, fetch data returned.
- if0_pc, out, WORD, PC presented to the IF0→IF1 register.
- if0_valid, out, 1, fetch valid presented to the IF0→IF1 register.
- fetch_cnt, out, 32, count of delivered fetches (perf counter).

Behaviour:
Reset:
- state=REQ, pc_r=PC_RST, hold_pc=0, fetch_cnt=0.
- icache_req=0 and if0_valid=0 while rst=1.

States REQ, WAIT, HOLD, DROP. At most one request outstanding.

Outputs:
- icache_req = (state==REQ) & !stall_in & !redirect_valid. Combinational; withdrawal before acceptance is legal.
- icache_addr = pc_r.
- if0_pc = pc_r in WAIT, hold_pc in HOLD.

REQ:
- redirect_valid → pc_r<=redirect_pc; stay REQ.
- Else icache_req & icache_addr_ok → WAIT.
- icache_data_ok in REQ is ignored.

WAIT:
- redirect_valid & data_ok → discard, pc_r<=redirect_pc, → REQ.
- redirect_valid & !data_ok → pc_r<=redirect_pc, → DROP.
- data_ok & !stall_in → if0_valid=1 this cycle, pc_r<=pc_r+4, → REQ.
- data_ok & stall_in → hold_pc<=pc_r, pc_r<=pc_r+4, → HOLD.

HOLD (one-entry skid for a response arriving during a stall):
- redirect_valid → drop held fetch, pc_r<=redirect_pc, → REQ.
- !stall_in → if0_valid=1, → REQ.
- Else stay.

DROP:
- Wait for data_ok; if0_valid=0; → REQ.
- A further redirect_valid in DROP updates pc_r and stays DROP until data_ok.

Rules:
- if0_valid is 1 only in the two cases above (WAIT delivery, HOLD release). Redirect always has priority over stall and delivery.
- fetch_cnt increments by 1 in every cycle with if0_valid=1; wraps modulo 2^32.
- pc_r+4 wraps modulo 2^32.
- Reset mid-operation returns to REQ at PC_RST. The ICache shares rst, so no response survives reset.

Decomposition:
- PC_RST, WORD and the state encoding (2-bit localparams) go in the shared CPU parameter header.
- No sub-module; single FSM plus PC and hold registers.

Test Plan:
- Reset release, addr_ok and data_ok each 1 cycle after req → addresses 1c000000, 1c000004, 1c000008; if0_valid pulses; fetch_cnt=3.
- data_ok while stall_in=1 for 3 cycles → no if0_valid during stall; if0_valid with if0_pc=1c000000 on the first unstalled cycle; next req at 1c000004.
- Redirect to 1c000100 while in WAIT, data_ok 2 cycles later → that data_ok gives if0_valid=0; next req addr=1c000100.
- Redirect to 1c000200 in the same cycle as data_ok → no if0_valid; next req addr=1c000200; fetch_cnt unchanged.
- Redirect while in HOLD with stall high → held fetch never delivered; req resumes at the redirect target after stall drops.
- rst asserted while in WAIT → icache_req=0 and if0_valid=0 during rst; first req after release at 1c000000; fetch_cnt=0.

Source files
------------

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared CPU parameter header for the IF0 fetch stage.
// Holds the reset PC, the datapath width, the fetch FSM encoding and the PC
// increment helper.
package if_fetch_ctrl_pkg;

    // Address/data width of the fetch path.
    localparam int WORD = 32;

    // Fetch PC after reset.
    localparam logic [WORD-1:0] PC_RST = 32'h1c00_0000;

    // Fetch FSM encoding (kept as plain 2-bit constants for legacy users).
    localparam logic [1:0] ST_REQ  = 2'd0;  // ready to issue a request
    localparam logic [1:0] ST_WAIT = 2'd1;  // request accepted, awaiting data
    localparam logic [1:0] ST_HOLD = 2'd2;  // data arrived during a stall, held
    localparam logic [1:0] ST_DROP = 2'd3;  // redirected, discard pending data

    // Sequential next PC; wraps modulo 2^WORD.
    function automatic logic [WORD-1:0] pc_incr(input logic [WORD-1:0] pc);
        pc_incr = pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Handshake bundle between the IF0 fetch controller, the pipeline control
// logic, the ICache and the IF0->IF1 register.
interface if_fetch_ctrl_if;
    import if_fetch_ctrl_pkg::*;

    logic            stall_in;
    logic            redirect_valid;
    logic [WORD-1:0] redirect_pc;
    logic            icache_req;
    logic [WORD-1:0] icache_addr;
    logic            icache_addr_ok;
    logic            icache_data_ok;
    logic [WORD-1:0] if0_pc;
    logic            if0_valid;
    logic [31:0]     fetch_cnt;

    // Fetch controller side.
    modport master (
        input  stall_in,
        input  redirect_valid,
        input  redirect_pc,
        output icache_req,
        output icache_addr,
        input  icache_addr_ok,
        input  icache_data_ok,
        output if0_pc,
        output if0_valid,
        output fetch_cnt
    );

    // Pipeline / ICache side.
    modport slave (
        output stall_in,
        output redirect_valid,
        output redirect_pc,
        input  icache_req,
        input  icache_addr,
        output icache_addr_ok,
        output icache_data_ok,
        input  if0_pc,
        input  if0_valid,
        input  fetch_cnt
    );

endinterface

// File: rtl/if_fetch_ctrl.sv
// IF0 fetch controller: owns the fetch PC, keeps at most one ICache request
// outstanding, applies stalls and redirects, discards stale responses after
// a redirect and presents PC/valid to the IF0->IF1 register.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    if_fetch_ctrl_if.master fetch_if
);

    logic [1:0]      state_q, state_d;
    logic [WORD-1:0] pc_q, pc_d;
    logic [WORD-1:0] hold_pc_q, hold_pc_d;
    logic [31:0]     fetch_cnt_q, fetch_cnt_d;
    logic            req_s;
    logic            deliver_s;

    // Next-state, PC and hold-register logic; redirect outranks stall/delivery.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        hold_pc_d = hold_pc_q;
        deliver_s = 1'b0;
        req_s     = (state_q == ST_REQ) && !fetch_if.stall_in &&
                    !fetch_if.redirect_valid && !rst;

        case (state_q)
            ST_REQ: begin
                // A response here cannot belong to us; it is ignored.
                if (fetch_if.redirect_valid) begin
                    pc_d = fetch_if.redirect_pc;
                end else if (req_s && fetch_if.icache_addr_ok) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (fetch_if.redirect_valid) begin
                    pc_d = fetch_if.redirect_pc;
                    if (fetch_if.icache_data_ok) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_DROP;
                    end
                end else if (fetch_if.icache_data_ok) begin
                    pc_d = pc_incr(pc_q);
                    if (!fetch_if.stall_in) begin
                        deliver_s = 1'b1;
                        state_d   = ST_REQ;
                    end else begin
                        hold_pc_d = pc_q;
                        state_d   = ST_HOLD;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (fetch_if.redirect_valid) begin
                    pc_d    = fetch_if.redirect_pc;
                    state_d = ST_REQ;
                end else if (!fetch_if.stall_in) begin
                    deliver_s = 1'b1;
                    state_d   = ST_REQ;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_DROP: begin
                // A later redirect just retargets; the stale response is
                // still outstanding until data_ok.
                if (fetch_if.redirect_valid) begin
                    pc_d = fetch_if.redirect_pc;
                end else begin
                    pc_d = pc_q;
                end
                if (fetch_if.icache_data_ok) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        fetch_cnt_d = deliver_s ? (fetch_cnt_q + 32'd1) : fetch_cnt_q;
    end

    // State, PC, hold PC and delivered-fetch counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_REQ;
            pc_q        <= PC_RST;
            hold_pc_q   <= '0;
            fetch_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_pc_q   <= hold_pc_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // The ICache handshake and IF0->IF1 valid are same-cycle signals by
    // protocol; both are forced low while reset is held.
    assign fetch_if.icache_req  = req_s;
    assign fetch_if.icache_addr = pc_q;
    assign fetch_if.if0_valid   = deliver_s && !rst;
    assign fetch_if.if0_pc      = (state_q == ST_HOLD) ? hold_pc_q : pc_q;
    assign fetch_if.fetch_cnt   = fetch_cnt_q;

endmodule
